uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the Riscv151 core: it turns the raw `FPGA_SERIAL_RX` pin into buffered bytes that the CPU's memory-mapped UART registers read. The block synchronizes the line and decodes 8N1 frames by mid-bit sampling. Received bytes go into a first-word-fall-through FIFO with a ready/valid pop port. Framing and overflow events are reported as single-cycle pulses for the CPU status register.

## Interface
- `CLOCK_FREQ`, 100_000_000, system clock in Hz
- `BAUD_RATE`, 115_200, line rate; SYMBOL = CLOCK_FREQ/BAUD_RATE (868), HALF = SYMBOL/2 (434)
- `FIFO_DEPTH`, 8, byte entries; power of two, >= 2

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset; clears all state when 0
- `serial_in`  in  1  raw RX pin, idle high, asynchronous to `clk`
- `data_out`  out  8  head-of-FIFO byte, valid when `data_out_valid`
- `data_out_valid`  out  1  FIFO non-empty
- `data_out_ready`  in  1  consumer pops head when high with valid
- `count`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `overflow`  out  1  one-cycle pulse: good byte dropped, FIFO full

## Operation
- Synchronizer: two flops on `serial_in`, both reset to 1; the decoder sees only `rx_s`, the second flop's output.
- Bit counter: 0..SYMBOL-1, restarts on every sample. Bit index: 0..7.
- Receive FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rx_s`=0, go to START and clear the counter.
- START: sample at counter = HALF-1. If `rx_s`=1 it is a glitch, so return to IDLE. Otherwise go to DATA with bit index 0 and clear the counter.
- DATA: sample at counter = SYMBOL-1 into shift register, LSB first. After bit 7, go to STOP.
- STOP: sample at counter = SYMBOL-1.
  - `rx_s`=1: push the byte and return to IDLE.
  - `rx_s`=0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This covers break conditions: a low line produces no repeated frames.
- FIFO: circular buffer with read and write pointers, each one bit wider than the index.
  - Full when the indices are equal and the MSBs differ; empty when the pointers are equal.
- Pop: when `data_out_valid` & `data_out_ready`.
- Push acceptance: the push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Push rejection: otherwise the byte is dropped, `overflow` pulses, and FIFO contents are unchanged.
- Simultaneous push and pop: `count` is unchanged and the data order is preserved.
  - When empty, a push and a pop cannot coincide because valid is low.
- `count` = write pointer minus read pointer, in full width.
- `data_out` = storage[read index], combinational from storage and the registered pointer. It is stable while `data_out_valid`=1 and no pop occurs.
- Reset values:
  - FSM in IDLE, counters 0, pointers 0.
  - Outputs: `data_out_valid`=0, `count`=0, `frame_err`=0, `overflow`=0.
  - `data_out` value unspecified (X allowed) while `data_out_valid`=0.
- Reset mid-frame: the partial byte is lost. After release, the FSM waits in IDLE, and the synchronizer's reset-to-1 prevents a false start.

## Timing
- Input latency: 2 cycles from pin to `rx_s`.
- Sample points, measured from the `rx_s` falling edge:
  - start bit at ~HALF cycles;
  - data bit k at ~HALF + (k+1)·SYMBOL;
  - stop bit at ~HALF + 9·SYMBOL, i.e. 8246 cycles at default parameters.
- Push latency: the byte is written on the stop-sample edge. `data_out_valid` and `count` update 1 cycle later.
- Pop latency: `count`, `data_out` and `data_out_valid` reflect the pop on the cycle after the accepting edge.
- `frame_err` and `overflow` are high for exactly one cycle, the cycle after the stop sample.
- Back-to-back frames: a start bit is accepted in the first IDLE cycle after STOP, so there is no dead time beyond the stop bit.
- Tolerance: decoding is correct for a sender baud error up to ±2%.

## Test plan
- Single byte: drive 0xA5 as 8N1 at 868 cycles/bit, `data_out_ready`=0. Expect `data_out_valid`=1 and `data_out`=0xA5, `count`=1, 8246±3 cycles after the falling edge. Then assert ready for 1 cycle and expect valid=0 and `count`=0.
- Burst and ordering: send 0x00, 0xFF, 0x55, 0x3C back-to-back with ready=0. Expect `count`=4, then pops in the order 0x00, 0xFF, 0x55, 0x3C.
- Overflow: with ready=0, send 9 bytes 0x01..0x09. Expect `count`=8 and a single `overflow` pulse at byte 9. Draining yields 0x01..0x08.
- Full with simultaneous pop: fill to 8, then hold ready=1 exactly on byte 9's stop-sample cycle. Expect no overflow, `count` stays 8, and 0x09 is last out.
- Framing/glitch:
  - Send 0x47 with stop bit driven low. Expect a `frame_err` pulse, no push, and no new frame until the line returns high; then 0x12 is received correctly.
  - A 200-cycle low glitch produces no push and no error.
- Reset mid-frame: drive `rst`=0 during bit 4 of 0x99, release, then send 0x66. Expect `count`=1 with `data_out`=0x66 only.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 mid-bit-sampling UART receiver feeding a FWFT byte FIFO with ready/valid pop
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF   = SYMBOL / 2;
    localparam int CW     = $clog2(SYMBOL);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(SYMBOL - 1);
    localparam logic [CW-1:0] MID  = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          stop_samp, push, pop, full, accept;

    assign stop_samp      = state == STOP && cnt == LAST;
    assign push           = stop_samp & rx_s;
    assign full           = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
    assign data_out_valid = wr_ptr != rd_ptr;
    assign pop            = data_out_valid & data_out_ready;
    assign accept         = push & (~full | pop);
    assign count          = wr_ptr - rd_ptr;
    assign data_out       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= serial_in;
            rx_s      <= rx_m;
            frame_err <= stop_samp & ~rx_s;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == MID) begin
                    state   <= rx_s ? IDLE : DATA;
                    cnt     <= '0;
                    bit_idx <= '0;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == LAST) begin
                    cnt     <= '0;
                    shift   <= {rx_s, shift[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == LAST) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : WAIT_HIGH;
                end else cnt <= cnt + 1'b1;
                WAIT_HIGH: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~accept;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr[AW-1:0]] <= shift;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at a reduced symbol length
module tb_uart_rx_fifo;
    localparam int CF = 3_200_000, BR = 100_000, SYM = CF / BR, HALF = SYM / 2;
    localparam int STOP_EDGE = 3 + HALF + 9 * SYM;

    logic       clk = 0, rst = 0, serial_in = 1, data_out_ready = 0;
    logic [7:0] data_out;
    logic       data_out_valid, frame_err, overflow;
    logic [3:0] count;
    int         n_chk = 0, n_bad = 0, fe_cnt = 0, ov_cnt = 0, fe_exp = 0, ov_exp = 0, lat;
    logic [7:0] exp_q[$];
    logic [7:0] burst [4] = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    logic [9:0] f;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .count(count), .frame_err(frame_err), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop = 1'b1, input int bc = SYM);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = fr[i];
            repeat (bc) @(negedge clk);
        end
    endtask

    task automatic sb_push(input logic [7:0] d);
        if (exp_q.size() < 8) exp_q.push_back(d);
        else ov_exp++;
    endtask

    task automatic pop_one(input string tag);
        int w;
        w = 0;
        while (!data_out_valid && w < 4 * STOP_EDGE) begin
            @(negedge clk);
            w++;
        end
        if (!data_out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        if (exp_q.size() == 0) chk({tag, "_extra"}, 1, 0);
        else chk(tag, data_out, exp_q.pop_front());
        data_out_ready = 1;
        @(negedge clk);
        data_out_ready = 0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_one(tag);
        chk({tag, "_cnt0"}, count, 0);
        chk({tag, "_valid0"}, data_out_valid, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ov", overflow, 0);
        rst = 1;
        repeat (2) @(negedge clk);

        sb_push(8'hA5);
        fork
            send(8'hA5);
            begin
                for (lat = 1; lat < 2 * STOP_EDGE; lat++) begin
                    @(posedge clk);
                    #1;
                    if (data_out_valid) break;
                end
                chk("a5_latency", lat, STOP_EDGE);
                chk("a5_data", data_out, 8'hA5);
            end
        join
        chk("a5_cnt", count, 1);
        pop_one("a5_pop");
        chk("a5_valid_after", data_out_valid, 0);
        chk("a5_cnt_after", count, 0);

        for (int i = 0; i < 4; i++) begin
            sb_push(burst[i]);
            send(burst[i]);
        end
        chk("burst_cnt", count, 4);
        drain("burst");

        for (int i = 1; i <= 9; i++) begin
            sb_push(8'(i));
            send(8'(i));
        end
        chk("ovf_cnt", count, 8);
        chk("ovf_pulses", ov_cnt, ov_exp);
        drain("ovf");

        for (int i = 0; i < 8; i++) begin
            sb_push(8'h11 + 8'(i));
            send(8'h11 + 8'(i));
        end
        chk("full_cnt", count, 8);
        fork
            send(8'h09);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                chk("fp_head", data_out, exp_q.pop_front());
                exp_q.push_back(8'h09);
                data_out_ready = 1;
                @(negedge clk);
                data_out_ready = 0;
                chk("fp_cnt", count, 8);
            end
        join
        chk("fp_no_ovf", ov_cnt, ov_exp);
        drain("fp");

        fe_exp++;
        send(8'h47, 1'b0);
        serial_in = 0;
        repeat (30 * SYM) @(negedge clk);
        serial_in = 1;
        repeat (SYM) @(negedge clk);
        chk("fe_pulses", fe_cnt, fe_exp);
        chk("fe_no_push", count, 0);
        sb_push(8'h12);
        send(8'h12);
        pop_one("fe_next");

        serial_in = 0;
        repeat (6) @(negedge clk);
        serial_in = 1;
        repeat (2 * STOP_EDGE) @(negedge clk);
        chk("glitch_cnt", count, 0);
        chk("glitch_fe", fe_cnt, fe_exp);

        sb_push(8'hC3);
        send(8'hC3, 1'b1, SYM - 1);
        sb_push(8'h3A);
        send(8'h3A, 1'b1, SYM + 1);
        drain("tol");

        sb_push(8'h5A);
        send(8'h5A);
        chk("pre_rst_cnt", count, 1);
        f = {1'b1, 8'h99, 1'b0};
        for (int i = 0; i < 5; i++) begin
            serial_in = f[i];
            repeat (i == 4 ? HALF : SYM) @(negedge clk);
        end
        rst = 0;
        serial_in = 1;
        #1;
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_valid", data_out_valid, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst = 1;
        repeat (2 * STOP_EDGE) @(negedge clk);
        chk("post_rst_cnt", count, 0);
        sb_push(8'h66);
        send(8'h66);
        chk("r66_cnt", count, 1);
        pop_one("r66");
        chk("final_cnt", count, 0);
        chk("final_fe", fe_cnt, fe_exp);
        chk("final_ov", ov_cnt, ov_exp);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
